alu_issue_ctrl: RTL and testbench

//  Initiator side of the 16-bit ALU interface. Accepts encoded instructions over valid/ready,

---
 rtl/alu_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational 16-bit ALU: accepts instructions over
// valid/ready, reads operands from an internal register file and writes the ALU result back.
module alu_issue_ctrl #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   input  logic              ld_en,
   input  logic [REG_AW-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [REG_AW-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   output logic [2:0]        ALU_Sel,
   input  logic [DATA_W-1:0] ALU_Out,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int NUM_REGS = 32'd1 << REG_AW;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      WB   = 2'b10
   } state_t;

   state_t            state_r;
   logic [DATA_W-1:0] regs_r [NUM_REGS];
   logic [REG_AW-1:0] rd_r;
   logic              ready_r;
   logic              done_r;
   logic [DATA_W-1:0] alu_a_r;
   logic [DATA_W-1:0] alu_b_r;
   logic [2:0]        alu_sel_r;
   logic [DATA_W-1:0] result_r;

   logic [2:0]        op_s;
   logic [REG_AW-1:0] rd_s;
   logic [REG_AW-1:0] rs1_s;
   logic [REG_AW-1:0] rs2_s;
   logic              accept_s;
   logic              ld_ok_s;
   logic              unused_s;

   assign op_s     = instr[15:13];
   assign rd_s     = instr[12:10];
   assign rs1_s    = instr[9:7];
   assign rs2_s    = instr[6:4];
   assign unused_s = ^instr[3:0];

   // ready_r mirrors state==IDLE but stays low through the reset cycle
   assign accept_s = instr_valid && ready_r && (state_r == IDLE);
   assign ld_ok_s  = ld_en && (state_r == IDLE) && !accept_s;

   // Issue FSM with registered ALU operands, handshake and writeback outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         ready_r   <= 1'b0;
         done_r    <= 1'b0;
         rd_r      <= '0;
         alu_a_r   <= '0;
         alu_b_r   <= '0;
         alu_sel_r <= 3'b000;
         result_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (accept_s) begin
                  rd_r      <= rd_s;
                  alu_a_r   <= regs_r[rs1_s];
                  alu_b_r   <= regs_r[rs2_s];
                  alu_sel_r <= op_s;
                  ready_r   <= 1'b0;
                  state_r   <= EXEC;
               end else begin
                  ready_r   <= 1'b1;
               end
            end
            EXEC: begin
               ready_r <= 1'b0;
               done_r  <= 1'b1;
               state_r <= WB;
            end
            WB: begin
               result_r <= ALU_Out;
               done_r   <= 1'b0;
               ready_r  <= 1'b1;
               state_r  <= IDLE;
            end
            default: begin
               ready_r <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Register file: writeback wins; host preload only in an idle, non-accepting cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (state_r == WB) begin
         regs_r[rd_r] <= ALU_Out;
      end else if (ld_ok_s) begin
         regs_r[ld_addr] <= ld_data;
      end
   end

   assign instr_ready = ready_r;
   assign done        = done_r;
   assign result      = result_r;
   assign ALU_A       = alu_a_r;
   assign ALU_B       = alu_b_r;
   assign ALU_Sel     = alu_sel_r;
   assign rd_data     = regs_r[rd_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: models the external ALU and a reference register file,
// pushes expected writebacks at accept and compares them when done pulses.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic        instr_ready;
   logic        ld_en = 1'b0;
   logic [2:0]  ld_addr = 3'd0;
   logic [15:0] ld_data = 16'h0000;
   logic [2:0]  rd_addr = 3'd0;
   logic [15:0] rd_data;
   logic [15:0] ALU_A;
   logic [15:0] ALU_B;
   logic [2:0]  ALU_Sel;
   logic [15:0] ALU_Out;
   logic        done;
   logic [15:0] result;

   alu_issue_ctrl #(.DATA_W(16), .REG_AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .ALU_A(ALU_A), .ALU_B(ALU_B),
      .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return ~a;
         3'b101:  return 16'h0000;
         default: return a;
      endcase
   endfunction

   assign ALU_Out = alu_f(ALU_Sel, ALU_A, ALU_B);

   typedef struct {
      logic [2:0]  rd;
      logic [2:0]  op;
      logic [15:0] val;
      logic [15:0] old;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] model [8];
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic preload(input logic [2:0] a, input logic [15:0] d, input bit honoured);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
      if (honoured) model[a] = d;
   endtask

   // Offers one instruction (valid left high) and returns the cycle of the accept edge
   task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, output int acc, output bit ok);
      exp_t e;
      instr = {op, rd, rs1, rs2, 4'h0};
      instr_valid = 1'b1;
      ok = 1'b0;
      acc = -1;
      for (int k = 0; k < 20; k++) begin
         if (instr_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) return;
      e.rd = rd; e.op = op;
      e.val = alu_f(op, model[rs1], model[rs2]);
      e.old = model[rd];
      @(posedge clk); #1;
      acc = cyc;
      sb.push_back(e);
      model[rd] = e.val;
      rd_addr = rd;
   endtask

   // Waits for done after an accept; returns latency, rd_data around the write edge
   task automatic wait_wb(output int lat, output logic [15:0] old_rd, output logic [15:0] res,
                          output logic [15:0] rd_after, output bit busy_bad, output bit pulse_bad);
      lat = -1; busy_bad = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (instr_ready) busy_bad = 1'b1;
         if (done) begin lat = k; break; end
      end
      old_rd = rd_data;
      @(posedge clk); @(negedge clk);
      pulse_bad = done;
      res = result;
      rd_after = rd_data;
   endtask

   task automatic test_reset();
      #2;
      n_tests++;
      if ({instr_ready, done, ALU_A, ALU_B, ALU_Sel, result} !== 51'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b done=%b A=%h B=%h sel=%h res=%h want all 0",
                  instr_ready, done, ALU_A, ALU_B, ALU_Sel, result);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (instr_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready_low: got %b want 0", instr_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (instr_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_after_reset: got %b want 1", instr_ready);
      end
   endtask

   task automatic test_reset_mid_exec();
      int acc; bit ok; int bad; int done_seen;
      preload(3'd1, 16'h1111, 1'b1);
      send(3'b000, 3'd2, 3'd1, 3'd1, acc, ok);
      instr_valid = 1'b0;
      rd_addr = 3'd1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({instr_ready, done, ALU_A, ALU_Sel, result, rd_data} !== 52'd0 || !ok) begin
         n_fail++;
         $display("FAIL reset_mid_exec: got ok=%b rdy=%b done=%b A=%h sel=%h res=%h r1=%h want 0",
                  ok, instr_ready, done, ALU_A, ALU_Sel, result, rd_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      n_tests++;
      if (done_seen != 0 || instr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_drop_op: got done_cycles=%0d rdy=%b want 0 and 1",
                  done_seen, instr_ready);
      end
      bad = 0;
      for (int r = 0; r < 8; r++) begin
         rd_addr = 3'(r); #1;
         if (rd_data !== 16'h0000) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL reset_regs_zero: got %0d nonzero regs want 0", bad);
      end
      for (int r = 0; r < 8; r++) model[r] = 16'h0000;
      sb.delete();
   endtask

   task automatic test_alu_ops();
      logic [11:0] tbl [10];
      int acc, lat; bit ok, busy_bad, pulse_bad; exp_t e;
      logic [15:0] old_rd, res, rd_after;
      tbl = '{{3'b000, 3'd3, 3'd1, 3'd2}, {3'b001, 3'd4, 3'd2, 3'd1},
              {3'b100, 3'd5, 3'd1, 3'd0}, {3'b010, 3'd7, 3'd1, 3'd2},
              {3'b011, 3'd0, 3'd1, 3'd2}, {3'b101, 3'd1, 3'd0, 3'd0},
              {3'b000, 3'd1, 3'd1, 3'd1}, {3'b111, 3'd6, 3'd2, 3'd0},
              {3'b110, 3'd5, 3'd3, 3'd4}, {3'b001, 3'd2, 3'd2, 3'd2}};
      preload(3'd1, 16'h0005, 1'b1);
      preload(3'd2, 16'h0003, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (i == 6) preload(3'd1, 16'h8001, 1'b1);
         send(tbl[i][11:9], tbl[i][8:6], tbl[i][5:3], tbl[i][2:0], acc, ok);
         instr_valid = 1'b0;
         wait_wb(lat, old_rd, res, rd_after, busy_bad, pulse_bad);
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL op%0d_accept: no accept seen want accept", i);
            continue;
         end
         e = sb.pop_front();
         n_tests++;
         if (lat != 2 || busy_bad || pulse_bad) begin
            n_fail++;
            $display("FAIL op%0d_timing: got lat=%0d busy_ready=%b done_late=%b want 2 0 0",
                     i, lat, busy_bad, pulse_bad);
         end
         n_tests++;
         if (res !== e.val || rd_after !== e.val || old_rd !== e.old) begin
            n_fail++;
            $display("FAIL op%0d_result: got res=%h reg=%h old=%h want %h %h %h",
                     i, res, rd_after, old_rd, e.val, e.val, e.old);
         end
         @(negedge clk);
         n_tests++;
         if (ALU_Sel !== e.op) begin
            n_fail++; $display("FAIL op%0d_sel_hold: got %b want %b", i, ALU_Sel, e.op);
         end
      end
      rd_addr = 3'd3; #1;
      n_tests++;
      if (rd_data !== 16'h0008) begin
         n_fail++; $display("FAIL add_r3: got %h want 0008", rd_data);
      end
      rd_addr = 3'd4; #1;
      n_tests++;
      if (rd_data !== 16'hFFFE) begin
         n_fail++; $display("FAIL sub_wrap_r4: got %h want fffe", rd_data);
      end
      rd_addr = 3'd1; #1;
      n_tests++;
      if (rd_data !== 16'h0002) begin
         n_fail++; $display("FAIL self_add_r1: got %h want 0002", rd_data);
      end
   endtask

   task automatic test_back_to_back();
      int acc [3]; int lat; bit ok, busy_bad, pulse_bad; exp_t e;
      logic [15:0] old_rd, res, rd_after;
      logic [2:0] rds [3];
      rds = '{3'd5, 3'd6, 3'd7};
      preload(3'd3, 16'h1234, 1'b1);
      preload(3'd4, 16'h0F0F, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send(3'(i), rds[i], 3'd3, 3'd4, acc[i], ok);
         wait_wb(lat, old_rd, res, rd_after, busy_bad, pulse_bad);
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL b2b%0d_accept: no accept seen want accept", i);
            continue;
         end
         e = sb.pop_front();
         n_tests++;
         if (res !== e.val || rd_after !== e.val || lat != 2 || busy_bad) begin
            n_fail++;
            $display("FAIL b2b%0d_result: got res=%h reg=%h lat=%0d busy=%b want %h %h 2 0",
                     i, res, rd_after, lat, busy_bad, e.val, e.val);
         end
      end
      instr_valid = 1'b0;
      n_tests++;
      if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d %0d want 3 3", acc[1] - acc[0], acc[2] - acc[1]);
      end
   endtask

   task automatic test_ld_gating();
      int acc, lat; bit ok, busy_bad, pulse_bad; exp_t e;
      logic [15:0] old_rd, res, rd_after;
      send(3'b011, 3'd7, 3'd1, 3'd1, acc, ok);
      instr_valid = 1'b0;
      ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'hBEEF;
      wait_wb(lat, old_rd, res, rd_after, busy_bad, pulse_bad);
      ld_en = 1'b0;
      if (sb.size() != 0) e = sb.pop_front();
      rd_addr = 3'd2; #1;
      n_tests++;
      if (rd_data !== model[2]) begin
         n_fail++; $display("FAIL ld_busy_ignored: got %h want %h", rd_data, model[2]);
      end
      preload(3'd2, 16'hBEEF, 1'b1);
      n_tests++;
      if (rd_data !== 16'hBEEF) begin
         n_fail++; $display("FAIL ld_idle: got %h want beef", rd_data);
      end
      ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h1234;
      send(3'b010, 3'd6, 3'd2, 3'd2, acc, ok);
      ld_en = 1'b0;
      instr_valid = 1'b0;
      wait_wb(lat, old_rd, res, rd_after, busy_bad, pulse_bad);
      if (sb.size() != 0) e = sb.pop_front();
      n_tests++;
      if (res !== 16'hBEEF || rd_after !== 16'hBEEF) begin
         n_fail++; $display("FAIL ld_accept_op: got res=%h reg=%h want beef beef", res, rd_after);
      end
      rd_addr = 3'd5; #1;
      n_tests++;
      if (rd_data !== model[5]) begin
         n_fail++; $display("FAIL ld_on_accept_ignored: got %h want %h", rd_data, model[5]);
      end
   endtask

   initial begin
      for (int r = 0; r < 8; r++) model[r] = 16'h0000;
      test_reset();
      test_reset_mid_exec();
      test_alu_ops();
      test_back_to_back();
      test_ld_gating();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
